// File: rtl/spin_write_arbiter_pkg.sv
// Shared types and default sizing for the spin write arbiter.
// The arbiter, its interface and the round-robin picker all import this package.
package spin_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NSPIN = 16;
  localparam int DEF_AW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  // A single requester still needs a 1-bit index, so never return zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spin_write_arbiter_if.sv
// Requester/bank bundle for the spin write arbiter.
// The master side drives requests and bank status; the slave side is the arbiter.
interface spin_write_arbiter_if
  import spin_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_stall;
  logic               clear_req;
  logic               clear_done;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic               wr_din;
  logic [7:0]         conflict_cnt;

  modport master (
    output req_valid, req_addr, req_data, wr_stall, clear_req,
    input  req_ready, clear_done, wr_en, wr_addr, wr_din, conflict_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall, clear_req,
    output req_ready, clear_done, wr_en, wr_addr, wr_din, conflict_cnt
  );

endinterface

// File: rtl/spin_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after the pointer,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import spin_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = idx_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [PW-1:0]   o_winner
);

  logic [PW-1:0] w_idx;

  assign o_any = |i_valid;

  // Walk from the farthest offset down so the nearest valid index is written last.
  always_comb begin
    w_idx    = '0;
    o_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(i_ptr) + k) % NREQ);
      if (i_valid[w_idx]) o_winner = w_idx;
    end
  end

endmodule

// File: rtl/spin_write_arbiter.sv
// Arbitrates single-bit writes from NREQ requesters into a spin register bank
// and sweeps the whole bank to zero on a clear request.
module spin_write_arbiter
  import spin_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NSPIN = DEF_NSPIN,
  parameter int AW    = DEF_AW
) (
  input logic                clk,
  input logic                reset,
  spin_write_arbiter_if.slave bus
);

  localparam int PW = idx_width(NREQ);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic            r_wr_en, w_wr_en_nxt;
  logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic            r_wr_din, w_wr_din_nxt;
  logic [NREQ-1:0] r_req_ready, w_req_ready_nxt;
  logic            r_clear_done, w_clear_done_nxt;
  logic [7:0]      r_conflict_cnt, w_conflict_cnt_nxt;
  logic            w_any;
  logic [PW-1:0]   w_winner;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_din       <= 1'b0;
      r_req_ready    <= '0;
      r_clear_done   <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_wr_en        <= w_wr_en_nxt;
      r_wr_addr      <= w_wr_addr_nxt;
      r_wr_din       <= w_wr_din_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_clear_done   <= w_clear_done_nxt;
      r_conflict_cnt <= w_conflict_cnt_nxt;
    end
  end

  // Every output is computed here one cycle ahead and then registered.
  always_comb begin
    w_state_nxt        = r_state;
    w_ptr_nxt          = r_ptr;
    w_wr_en_nxt        = 1'b0;
    w_wr_addr_nxt      = r_wr_addr;
    w_wr_din_nxt       = r_wr_din;
    w_req_ready_nxt    = '0;
    w_clear_done_nxt   = 1'b0;
    w_conflict_cnt_nxt = r_conflict_cnt;

    case (r_state)
      ST_IDLE: begin
        if ($countones(bus.req_valid) >= 2 && r_conflict_cnt != 8'hFF)
          w_conflict_cnt_nxt = r_conflict_cnt + 8'd1;
        if (bus.clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = '0;
          w_wr_din_nxt  = 1'b0;
        end else if (!bus.wr_stall && w_any) begin
          w_state_nxt               = ST_WRITE;
          w_wr_en_nxt               = 1'b1;
          w_wr_addr_nxt             = bus.req_addr[int'(w_winner)*AW +: AW];
          w_wr_din_nxt              = bus.req_data[w_winner];
          w_req_ready_nxt[w_winner] = 1'b1;
          w_ptr_nxt = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (r_wr_addr == AW'(NSPIN - 1)) begin
          w_state_nxt      = ST_IDLE;
          w_clear_done_nxt = 1'b1;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_wr_addr + 1'b1;
          w_wr_din_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.clear_done   = r_clear_done;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_din       = r_wr_din;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_spin_write_arbiter.sv
// Directed self-checking bench for spin_write_arbiter: a vector table for
// single grants plus sequences for fairness, clear, stall, reset and saturation.
module tb_spin_write_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [3:0]  data;
    logic        stall;
    logic        expEn;
    logic [3:0]  expAddr;
    logic        expDin;
    logic [3:0]  expReady;
    logic [7:0]  expCnt;
  } vec_t;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  vec_t vecs[7];

  spin_write_arbiter_if #(.NREQ(4), .AW(4)) bus ();

  spin_write_arbiter #(.NREQ(4), .NSPIN(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req_valid = v.valid;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    bus.wr_stall  = v.stall;
    bus.clear_req = 1'b0;
  endtask

  task automatic idleInputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.wr_stall  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({tag, " wr_addr"}, 32'(bus.wr_addr), 32'd0);
    checkOutput({tag, " wr_din"}, 32'(bus.wr_din), 32'd0);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, " clear_done"}, 32'(bus.clear_done), 32'd0);
    checkOutput({tag, " conflict_cnt"}, 32'(bus.conflict_cnt), 32'd0);
  endtask

  initial begin
    int doneSeen;
    int enSeen;
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b0;
    idleInputs();

    vecs[0] = '{4'b0001, 16'h0005, 4'b0001, 1'b0, 1'b1, 4'd5,  1'b1, 4'b0001, 8'd0};
    vecs[1] = '{4'b0001, 16'h0003, 4'b0000, 1'b0, 1'b1, 4'd3,  1'b0, 4'b0001, 8'd0};
    vecs[2] = '{4'b1001, 16'hC007, 4'b1000, 1'b0, 1'b1, 4'd12, 1'b1, 4'b1000, 8'd1};
    vecs[3] = '{4'b0110, 16'h0A90, 4'b0010, 1'b0, 1'b1, 4'd9,  1'b1, 4'b0010, 8'd2};
    vecs[4] = '{4'b0110, 16'h0A90, 4'b0010, 1'b0, 1'b1, 4'd10, 1'b0, 4'b0100, 8'd3};
    vecs[5] = '{4'b0011, 16'h0021, 4'b0010, 1'b0, 1'b1, 4'd1,  1'b0, 4'b0001, 8'd4};
    vecs[6] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 4'd1,  1'b0, 4'b0000, 8'd4};

    doReset();
    checkAllZero("reset");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d wr_din", i), 32'(bus.wr_din), 32'(vecs[i].expDin));
      checkOutput($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d conflict_cnt", i), 32'(bus.conflict_cnt), 32'(vecs[i].expCnt));
      idleInputs();
      tick();
      checkOutput($sformatf("vec%0d back idle wr_en", i), 32'(bus.wr_en), 32'd0);
    end

    // Fairness: all four requesters held valid from a fresh pointer.
    doReset();
    bus.req_valid = 4'b1111;
    bus.req_addr  = 16'hBA98;
    bus.req_data  = 4'b1010;
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput($sformatf("fair%0d req_ready", g), 32'(bus.req_ready), 32'(4'b0001 << (g % 4)));
      checkOutput($sformatf("fair%0d wr_addr", g), 32'(bus.wr_addr), 32'(8 + (g % 4)));
      checkOutput($sformatf("fair%0d wr_din", g), 32'(bus.wr_din), 32'((g % 4) & 1));
      checkOutput($sformatf("fair%0d conflict_cnt", g), 32'(bus.conflict_cnt), 32'(g + 1));
      tick();
      checkOutput($sformatf("fair%0d gap wr_en", g), 32'(bus.wr_en), 32'd0);
    end

    // Clear takes precedence over a simultaneous request.
    doReset();
    bus.clear_req = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_addr  = 16'h0060;
    bus.req_data  = 4'b0010;
    tick();
    bus.clear_req = 1'b0;
    for (int a = 0; a < 16; a++) begin
      checkOutput($sformatf("clear%0d wr_en", a), 32'(bus.wr_en), 32'd1);
      checkOutput($sformatf("clear%0d wr_addr", a), 32'(bus.wr_addr), 32'(a));
      checkOutput($sformatf("clear%0d wr_din", a), 32'(bus.wr_din), 32'd0);
      checkOutput($sformatf("clear%0d req_ready", a), 32'(bus.req_ready), 32'd0);
      checkOutput($sformatf("clear%0d clear_done", a), 32'(bus.clear_done), 32'd0);
      tick();
    end
    checkOutput("clear_done pulse", 32'(bus.clear_done), 32'd1);
    checkOutput("clear end wr_en", 32'(bus.wr_en), 32'd0);
    tick();
    checkOutput("post-clear clear_done", 32'(bus.clear_done), 32'd0);
    checkOutput("post-clear req_ready", 32'(bus.req_ready), 32'(4'b0010));
    checkOutput("post-clear wr_addr", 32'(bus.wr_addr), 32'd6);
    checkOutput("post-clear wr_din", 32'(bus.wr_din), 32'd1);
    idleInputs();

    // Stall blocks acceptance until it drops.
    doReset();
    bus.req_valid = 4'b0100;
    bus.req_addr  = 16'h0B00;
    bus.req_data  = 4'b0100;
    bus.wr_stall  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput($sformatf("stall%0d wr_en", s), 32'(bus.wr_en), 32'd0);
      checkOutput($sformatf("stall%0d req_ready", s), 32'(bus.req_ready), 32'd0);
    end
    bus.wr_stall = 1'b0;
    tick();
    checkOutput("unstall req_ready", 32'(bus.req_ready), 32'(4'b0100));
    checkOutput("unstall wr_addr", 32'(bus.wr_addr), 32'd11);
    checkOutput("unstall wr_en", 32'(bus.wr_en), 32'd1);
    idleInputs();

    // Reset lands in the middle of a clear sweep.
    doReset();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (7) tick();
    checkOutput("pre-abort wr_addr", 32'(bus.wr_addr), 32'd7);
    reset = 1'b1;
    #1;
    checkAllZero("async abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    doneSeen = 0;
    enSeen   = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.clear_done === 1'b1) doneSeen++;
      if (bus.wr_en === 1'b1) enSeen++;
    end
    checkOutput("no clear_done after abort", 32'(doneSeen), 32'd0);
    checkOutput("no wr_en after abort", 32'(enSeen), 32'd0);

    // Saturation: contenders held off by stall so every cycle is an IDLE cycle.
    doReset();
    bus.req_valid = 4'b0011;
    bus.wr_stall  = 1'b1;
    repeat (254) tick();
    checkOutput("sat at 254", 32'(bus.conflict_cnt), 32'd254);
    tick();
    checkOutput("sat at 255", 32'(bus.conflict_cnt), 32'd255);
    repeat (45) tick();
    checkOutput("sat after 300", 32'(bus.conflict_cnt), 32'd255);
    repeat (5) tick();
    checkOutput("sat holds", 32'(bus.conflict_cnt), 32'd255);
    idleInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/spin_write_arbiter.md
SPIN_WRITE_ARBITER -- requirements
Module: spin_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters.
REQ-002 Parameter NSPIN, default 16: depth of the downstream single-bit register bank.
REQ-003 Parameter AW, default 4: address width, SHALL equal clog2(NSPIN).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester write request, held until accepted.
REQ-007 req_addr  input  NREQ*AW  packed target addresses, requester i at [i*AW +: AW].
REQ-008 req_data  input  NREQ  per-requester write bit.
REQ-009 req_ready  output  NREQ  one-hot acceptance pulse, one cycle.
REQ-010 wr_stall  input  1  downstream bank busy; blocks new acceptances.
REQ-011 clear_req  input  1  level request to zero the whole bank.
REQ-012 clear_done  output  1  one-cycle pulse on completion of a clear sweep.
REQ-013 wr_en  output  1  bank write enable.
REQ-014 wr_addr  output  AW  bank write address.
REQ-015 wr_din  output  1  bank write data.
REQ-016 conflict_cnt  output  8  saturating count of cycles with multiple contenders.

Function
REQ-017 FSM states: IDLE, WRITE, CLEAR; all outputs registered.
REQ-018 IDLE: clear_req=1 SHALL go to CLEAR, taking precedence over requests; clear_req is ignored outside IDLE.
REQ-019 IDLE: clear_req=0, wr_stall=0, any req_valid -> select winner, latch its addr/data, go to WRITE.
REQ-020 Winner selection: round-robin, first valid index at or after ptr, wrapping NREQ-1 -> 0.
REQ-021 On acceptance, ptr SHALL become (winner+1) mod NREQ; ptr is otherwise unchanged.
REQ-022 WRITE (exactly one cycle): wr_en=1, wr_addr/wr_din = latched values, req_ready[winner]=1; next state IDLE.
REQ-023 Latency: valid seen in IDLE at cycle t -> wr_en and req_ready in cycle t+1; max throughput one write per 2 cycles.
REQ-024 Requester SHALL drop or update valid the cycle after ready; a still-high valid in IDLE counts as a new request.
REQ-025 wr_stall=1 in IDLE SHALL block acceptance; wr_stall in WRITE or CLEAR has no effect.
REQ-026 CLEAR: wr_en=1, wr_din=0, wr_addr stepping 0..NSPIN-1, one address per cycle; no req_ready during CLEAR.
REQ-027 After the wr_addr=NSPIN-1 cycle: clear_done=1 for exactly one cycle, state IDLE.
REQ-028 Outside WRITE/CLEAR: wr_en=0, req_ready=0; wr_addr/wr_din hold their last values.
REQ-029 conflict_cnt SHALL increment in any IDLE cycle with two or more req_valid bits set, saturating at 255.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, ptr=0, wr_en=0, wr_addr=0, wr_din=0, req_ready=0, clear_done=0, conflict_cnt=0.
REQ-031 Reset asserted mid-WRITE or mid-CLEAR SHALL abort without completion pulses; a clear is not resumed after reset.

Structure
REQ-032 Shared package spin_arb_pkg SHALL hold the state enum and the NREQ/NSPIN/AW defaults.
REQ-033 One combinational sub-module rr_pick (inputs valid vector and ptr; outputs any-valid flag and winner index) SHALL implement REQ-020.

Verification
REQ-034 Single request: req_valid=0001, addr0=5, data0=1 in IDLE -> next cycle wr_en=1, wr_addr=5, wr_din=1, req_ready=0001.
REQ-035 Fairness: all four valid continuously, ptr=0 -> grants 0,1,2,3,0 on alternate cycles; conflict_cnt increments once per IDLE cycle.
REQ-036 Clear priority: clear_req=1 together with req_valid=0010 -> 16 consecutive writes of 0 to addr 0..15, then clear_done pulse, then requester 1 granted.
REQ-037 Stall: wr_stall=1 for 3 cycles with req_valid=0100 -> no wr_en; grant in the cycle after wr_stall falls.
REQ-038 Reset mid-CLEAR at addr 7 -> all outputs 0 asynchronously, no clear_done, IDLE after reset release.
REQ-039 Saturation: 300 multi-contender IDLE cycles -> conflict_cnt=255 and holds.
